trng_postproc: RTL and testbench
================================

Name: trng_postproc

Overview:
- Downstream consumer of the STR TRNG core's sampled random bus. It sits in the clk domain directly after the core's final clk-sampled stage.
- Each clk cycle it XOR-compresses the IN_W-bit bus to one raw bit, runs a repetition-count health test, and assembles OUT_W-bit words.
- Words go into a small first-word-fall-through (FWFT) FIFO, read over a valid/ready handshake.
- A warm-up phase discards samples after enable while the rings settle.

Parameters:
- IN_W, 16: width of rnddata; equals STR ring length.
- OUT_W, 32: output word width in bits, >=2.
- FIFO_DEPTH, 4: word FIFO depth; power of 2, >=2.
- WARMUP_CYC, 64: clk cycles discarded after entering WARMUP, >=1.
- RCT_CUTOFF, 31: consecutive identical raw bits that trigger the alarm, >=2.

Ports:
- clk  in  1  sample clock.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  enable generation.
- rnddata  in  IN_W  random bus from the core, already clk-synchronous.
- alarm_clr  in  1  clears the alarm; level-sampled.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  OUT_W  head word of the FIFO.
- rd_ready  in  1  consumer accepts the word.
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of words stored.
- alarm  out  1  health-test failure, sticky.
- running  out  1  state==RUN.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; all counters, shift register and FIFO pointers cleared.
  - Outputs: rd_valid=0, rd_data=0, fifo_level=0, alarm=0, running=0.
- Raw bit: raw = XOR-reduction of rnddata, combinational, consumed at the same clk edge.
- State machine (registered, one transition per cycle):
  - IDLE: waits for en=1, then goes to WARMUP. The FIFO keeps its contents and stays readable.
  - WARMUP:
    - Counts WARMUP_CYC cycles; raw bits are discarded.
    - Goes to RUN on the edge ending the WARMUP_CYC-th cycle.
    - en=0 returns to IDLE and clears the counter.
  - RUN:
    - Accepted bits are shifted in LSB-first: shreg <= {bit, shreg[OUT_W-1:1]}, bitcnt++. The first accepted bit of a word ends up in bit 0.
    - When the OUT_W-th bit is accepted, the completed word (including that bit) is pushed and bitcnt returns to 0.
    - en=0 returns to IDLE; a partial word is discarded and bitcnt=0.
  - ALARM:
    - Entered from RUN when the repetition counter reaches RCT_CUTOFF.
    - On entry: alarm=1, FIFO flushed (level 0, rd_valid=0 next cycle), shreg and bitcnt cleared.
    - No pushes while in ALARM.
    - alarm_clr=1 returns to IDLE with alarm=0; if en is still 1, IDLE goes to WARMUP on the next cycle.
- Repetition-count test (RUN only, on raw bits, independent of the optional feature):
  - rct_cnt=1 on the first RUN cycle.
  - raw equal to the previous raw: rct_cnt++, saturating; different: rct_cnt=1.
  - rct_cnt==RCT_CUTOFF: go to ALARM on the next edge. The word completing in that same cycle is not pushed.
  - Leaving RUN resets the test.
- FIFO (FWFT):
  - rd_data is the head word whenever rd_valid=1; rd_data=0 when empty.
  - Pop on rd_valid & rd_ready.
  - Push onto a full FIFO with no simultaneous pop: the word is dropped, nothing is overwritten.
  - Push and pop in the same cycle while full: both accepted, level unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect (pop needs rd_valid).
  - Latency: word completed at edge N gives rd_valid=1 after edge N (registered).
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is registered.
- rd_ready is ignored when rd_valid=0.

Optional Feature:
- Macro: TRNG_VN_DEBIAS_EN.
- Defined: von Neumann corrector between raw and the shift register in RUN.
  - Raw bits are paired: the first of a pair is held, the second completes the pair.
  - Pair 01 emits 0, pair 10 emits 1, pairs 00 and 11 emit nothing.
  - Pairing restarts on entry to RUN.
  - Only emitted bits are accepted into shreg.
- Undefined: every RUN cycle accepts raw directly; no pairing logic is synthesised.

Test Plan:
- Fixed bit latency (feature off, defaults):
  - Stimulus: after reset, en=1 at cycle 0, rnddata alternating 0x0001/0x0000 starting 0x0001 at the first RUN cycle.
  - Response: running=1 from cycle 64; rd_valid rises after the edge ending RUN cycle 32; rd_data=0x55555555; fifo_level=1.
- Repetition alarm: rnddata held at 0x8001 (raw=0) in RUN -> alarm=1 after exactly 31 RUN cycles; FIFO flushed, rd_valid=0. Then alarm_clr=1 with en=1 -> IDLE, then WARMUP again, alarm=0.
- FIFO full:
  - Alternating stimulus with rd_ready=0 -> fifo_level saturates at 4; the 5th word is dropped.
  - Then rd_ready=1 for 4 cycles -> four reads of 0x55555555, level 0.
  - Simultaneous push and pop while full keeps level 4.
- Disable mid-word: en=0 after 10 RUN bits -> IDLE, partial word discarded. Re-enable -> WARMUP for 64 cycles; the first word contains no stale bits.
- Async reset mid-operation: rstn low while FIFO level=3 and in RUN -> immediate rd_valid=0, fifo_level=0, alarm=0, running=0.
- TRNG_VN_DEBIAS_EN defined:
  - Raw pattern 1,0 repeated (emit 1 per pair) -> word 0xFFFFFFFF after 64 RUN cycles.
  - Raw pattern 1,1,0,0 repeated -> no words, no alarm.

Source files
------------

// File: rtl/trng_postproc.sv
// trng_postproc: XOR-compress TRNG bus, repetition-count health test, word assembly into FWFT FIFO.
// Optional von Neumann debiasing when TRNG_VN_DEBIAS_EN is defined.
module trng_postproc #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int WARMUP_CYC = 64,
  parameter int RCT_CUTOFF = 31
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [IN_W-1:0]               rnddata,
  input  logic                          alarm_clr,
  output logic                          rd_valid,
  output logic [OUT_W-1:0]              rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          alarm,
  output logic                          running
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(OUT_W + 1);
  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  typedef enum logic [1:0] {IDLE, WARMUP, RUN, ALARM} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [RW-1:0] rct_q, rct_d;
  logic prev_q;
  logic [OUT_W-1:0] shreg_q, shreg_d, word;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic raw, run_act, trip, acc, bit_in, word_done, push, pop, push_ok, warm_done;
  assign raw = ^rnddata;
  assign run_act = state_q == RUN && en;
  // rct_q==0 marks the first RUN cycle, where the run length starts at 1
  assign rct_d = !run_act ? '0 : (rct_q != '0 && raw == prev_q) ?
                 (rct_q == RW'(RCT_CUTOFF) ? rct_q : rct_q + RW'(1)) : RW'(1);
  assign trip = run_act && rct_d == RW'(RCT_CUTOFF);
`ifdef TRNG_VN_DEBIAS_EN
  logic have_q, held_q;
  assign acc = run_act && have_q && held_q != raw;
  assign bit_in = held_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      have_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      have_q <= run_act && !trip && !have_q;
      held_q <= raw;
    end
`else
  assign acc = run_act;
  assign bit_in = raw;
`endif
  assign word = {bit_in, shreg_q[OUT_W-1:1]};
  assign word_done = acc && bitcnt_q == BW'(OUT_W - 1);
  assign push = word_done && !trip;
  assign shreg_d = (!run_act || trip || word_done) ? '0 : acc ? word : shreg_q;
  assign bitcnt_d = (!run_act || trip || word_done) ? '0 : bitcnt_q + BW'(acc);
  assign warm_done = wcnt_q == WW'(WARMUP_CYC - 1);
  assign wcnt_d = (state_q == WARMUP && en && !warm_done) ? wcnt_q + WW'(1) : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? WARMUP : IDLE;
      WARMUP:  state_d = !en ? IDLE : warm_done ? RUN : WARMUP;
      RUN:     state_d = !en ? IDLE : trip ? ALARM : RUN;
      default: state_d = alarm_clr ? IDLE : ALARM;
    endcase
  end
  assign rd_valid = lvl_q != '0;
  assign rd_data = rd_valid ? mem[rp_q] : '0;
  assign pop = rd_valid && rd_ready;
  assign push_ok = push && (lvl_q != LW'(FIFO_DEPTH) || pop);
  // entering ALARM flushes the FIFO; pops in that cycle are moot
  assign wp_d = trip ? '0 : wp_q + AW'(push_ok);
  assign rp_d = trip ? '0 : rp_q + AW'(pop);
  assign lvl_d = trip ? '0 : lvl_q + LW'(push_ok) - LW'(pop);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      bitcnt_q <= '0;
      rct_q    <= '0;
      prev_q   <= 1'b0;
      shreg_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      lvl_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      bitcnt_q <= bitcnt_d;
      rct_q    <= rct_d;
      prev_q   <= raw;
      shreg_q  <= shreg_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      lvl_q    <= lvl_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wp_q] <= word;
  assign fifo_level = lvl_q;
  assign alarm = state_q == ALARM;
  assign running = state_q == RUN;
endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: directed and randomized checks of trng_postproc against a queue-based reference model.
module tb_trng_postproc;
  localparam int IN_W = 16, OUT_W = 32, DEPTH = 4, WARM = 64, CUT = 31;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, alarm_clr = 1'b0, rd_ready = 1'b0;
  logic [IN_W-1:0] rnddata = '0;
  logic rd_valid, alarm, running;
  logic [OUT_W-1:0] rd_data;
  logic [$clog2(DEPTH):0] fifo_level;
  int checks = 0, errors = 0;
  logic altb;
  logic [31:0] q[$];
  logic [31:0] acc_w;
  int nb, run_len, prev, raw;
  bit tripped;

  always #5 clk = ~clk;

  trng_postproc dut (
    .clk(clk), .rstn(rstn), .en(en), .rnddata(rnddata), .alarm_clr(alarm_clr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .fifo_level(fifo_level), .alarm(alarm), .running(running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // from IDLE: one edge into WARMUP, then WARM cycles before RUN
  task automatic warmup();
    en = 1'b1;
    tick();
    repeat (WARM - 1) tick();
    chk("warmup_not_running", running, 0);
    tick();
    chk("running_after_warmup", running, 1);
  endtask

  task automatic alt(input int n);
    for (int i = 0; i < n; i++) begin
      rnddata = {15'b0, altb};
      tick();
      altb = ~altb;
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_running", running, 0);
    rstn = 1'b1;
    tick();
`ifdef TRNG_VN_DEBIAS_EN
    warmup();
    altb = 1'b1;
    alt(63);
    chk("vn_no_early_word", rd_valid, 0);
    alt(1);
    chk("vn_valid", rd_valid, 1);
    chk("vn_word", rd_data, 32'hFFFFFFFF);
    chk("vn_level", fifo_level, 1);
    for (int i = 0; i < 200; i++) begin
      rnddata = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
      tick();
    end
    chk("vn_pairs_equal_no_words", fifo_level, 1);
    chk("vn_pairs_no_alarm", alarm, 0);
`else
    // fixed latency and FIFO full behaviour
    warmup();
    rd_ready = 1'b0;
    altb = 1'b1;
    alt(31);
    chk("no_early_word", rd_valid, 0);
    alt(1);
    chk("first_valid", rd_valid, 1);
    chk("first_word", rd_data, 32'h55555555);
    chk("first_level", fifo_level, 1);
    alt(96);
    chk("full_level", fifo_level, 4);
    alt(32);
    chk("drop_level", fifo_level, 4);
    chk("drop_head", rd_data, 32'h55555555);
    alt(31);
    rd_ready = 1'b1;
    alt(1);
    chk("push_pop_full", fifo_level, 4);
    rd_ready = 1'b0;
    en = 1'b0;
    tick();
    chk("disable_idle", running, 0);
    chk("idle_keeps_fifo", fifo_level, 4);
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_word", rd_data, 32'h55555555);
      tick();
    end
    chk("drained_level", fifo_level, 0);
    chk("drained_valid", rd_valid, 0);
    chk("drained_data", rd_data, 0);
    rd_ready = 1'b0;
    // disable mid-word, then randomized run against the model
    warmup();
    rnddata = 16'h0001;
    repeat (10) tick();
    en = 1'b0;
    tick();
    chk("midword_idle", running, 0);
    chk("midword_no_word", fifo_level, 0);
    warmup();
    acc_w = '0; nb = 0; prev = -1; run_len = 0; tripped = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rnddata = IN_W'($urandom);
      rd_ready = 1'($urandom);
      chk("rand_valid", rd_valid, q.size() != 0);
      chk("rand_level", fifo_level, q.size());
      chk("rand_data", rd_data, q.size() != 0 ? q[0] : 32'h0);
      raw = $countones(rnddata) % 2;
      run_len = (raw == prev) ? run_len + 1 : 1;
      prev = raw;
      if (run_len >= CUT) begin
        tick();
        tripped = 1'b1;
        q.delete();
        break;
      end
      if (q.size() != 0 && rd_ready) void'(q.pop_front());
      acc_w[nb] = raw[0];
      nb++;
      if (nb == OUT_W) begin
        if (q.size() < DEPTH) q.push_back(acc_w);
        nb = 0;
        acc_w = '0;
      end
      tick();
    end
    chk("rand_alarm", alarm, tripped);
    en = 1'b0;
    alarm_clr = 1'b1;
    rd_ready = 1'b0;
    tick();
    alarm_clr = 1'b0;
    chk("rand_final_level", fifo_level, q.size());
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("rand_drain", rd_data, q.size() != 0 ? q[0] : 32'h0);
      if (q.size() != 0) void'(q.pop_front());
      tick();
    end
    chk("rand_drained", fifo_level, 0);
    rd_ready = 1'b0;
    // repetition alarm with a word already queued
    warmup();
    altb = 1'b0;
    alt(32);
    chk("pre_alarm_level", fifo_level, 1);
    chk("pre_alarm_word", rd_data, 32'hAAAAAAAA);
    rnddata = 16'h8001;
    repeat (30) tick();
    chk("no_early_alarm", alarm, 0);
    chk("still_running", running, 1);
    tick();
    chk("alarm_set", alarm, 1);
    chk("alarm_not_running", running, 0);
    chk("alarm_flush_valid", rd_valid, 0);
    chk("alarm_flush_level", fifo_level, 0);
    chk("alarm_flush_data", rd_data, 0);
    repeat (3) tick();
    chk("alarm_sticky", alarm, 1);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    chk("alarm_cleared", alarm, 0);
    chk("cleared_idle", running, 0);
    warmup();
    // async reset mid-operation
    altb = 1'b1;
    alt(96);
    chk("pre_reset_level", fifo_level, 3);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_alarm", alarm, 0);
    chk("arst_running", running, 0);
    chk("arst_data", rd_data, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
